// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and helpers for the sequential adder.
// Imported by the FSM top and the normalize step.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int MNT_W = MAN_W + 1;
  localparam int SUM_W = MAN_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  function automatic fp32_t fp_unpack(input logic [31:0] w);
    return fp32_t'(w);
  endfunction

  function automatic logic [31:0] fp_pack(
    input logic             s,
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    return {s, e, m};
  endfunction

  // Denormals flush to zero, so the hidden bit is simply exp != 0.
  function automatic logic [MNT_W-1:0] fp_mant(input fp32_t f);
    return (f.exp != '0) ? {1'b1, f.man} : '0;
  endfunction

endpackage

// File: rtl/fp_norm_step.sv
// One normalize step: carry right-shift, zero, single left-shift
// with underflow flush, or already normalized.
module fp_norm_step
  import fp32_pkg::*;
(
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [SUM_W-1:0] man_i,
  output logic             sign_o,
  output logic [EXP_W-1:0] exp_o,
  output logic [SUM_W-1:0] man_o,
  output logic             done_o,
  output logic             ovf_o
);

  always_comb begin
    sign_o = sign_i;
    exp_o  = exp_i;
    man_o  = man_i;
    done_o = 1'b1;
    ovf_o  = 1'b0;
    if (man_i[SUM_W-1]) begin
      man_o = {1'b0, man_i[SUM_W-1:1]};
      exp_o = exp_i + 1'b1;
      if (exp_o == EXP_MAX) begin
        man_o = '0;
        ovf_o = 1'b1;
      end
    end else if (man_i == '0) begin
      sign_o = 1'b0;
      exp_o  = '0;
    end else if (!man_i[MAN_W]) begin
      if (exp_i <= EXP_W'(1)) begin
        exp_o = '0;
        man_o = '0;
      end else begin
        man_o  = {man_i[SUM_W-2:0], 1'b0};
        exp_o  = exp_i - 1'b1;
        // look ahead so a finished shift leaves NORM the same cycle
        done_o = man_i[MAN_W-1];
      end
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder: unpack, align, add, normalize, pack,
// with valid/ready on both operand and result sides.
module fp_add_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum_out,
  output logic [2:0]  flags_out,
  output logic        busy
);

  state_t state_q, state_d;

  logic             sx_q, sx_d, sy_q, sy_d;
  logic [EXP_W-1:0] ex_q, ex_d, ey_q, ey_d;
  logic [MNT_W-1:0] mx_q, mx_d, my_q, my_d;
  logic [SUM_W-1:0] man_q, man_d;
  logic             sub_q, sub_d;
  logic             nan_q, nan_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      sum_q, sum_d;
  logic [2:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  fp32_t a_f, b_f;
  logic  a_nan, b_nan, a_inf, b_inf;

  assign a_f   = fp_unpack(a_in);
  assign b_f   = fp_unpack(b_in);
  assign a_nan = (a_f.exp == EXP_MAX) && (a_f.man != '0);
  assign b_nan = (b_f.exp == EXP_MAX) && (b_f.man != '0);
  assign a_inf = (a_f.exp == EXP_MAX) && (a_f.man == '0);
  assign b_inf = (b_f.exp == EXP_MAX) && (b_f.man == '0);

  logic             x_is_a;
  logic             sb, ss;
  logic [EXP_W-1:0] eb, es, dexp;
  logic [MNT_W-1:0] mb, ms, ms_sh;

  assign x_is_a = {ex_q, mx_q} >= {ey_q, my_q};
  assign {sb, eb, mb, ss, es, ms} = x_is_a ?
    {sx_q, ex_q, mx_q, sy_q, ey_q, my_q} :
    {sy_q, ey_q, my_q, sx_q, ex_q, mx_q};
  assign dexp  = eb - es;
  assign ms_sh = (dexp >= EXP_W'(SUM_W)) ? '0 : (ms >> dexp);

  logic             n_sign, n_done, n_ovf;
  logic [EXP_W-1:0] n_exp;
  logic [SUM_W-1:0] n_man;

  fp_norm_step u_norm (
    .sign_i (sx_q),
    .exp_i  (ex_q),
    .man_i  (man_q),
    .sign_o (n_sign),
    .exp_o  (n_exp),
    .man_o  (n_man),
    .done_o (n_done),
    .ovf_o  (n_ovf)
  );

  logic res_zero;
  assign res_zero = (ex_q == '0) && (man_q[MAN_W-1:0] == '0);

  always_comb begin
    state_d     = state_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    ex_d        = ex_q;
    ey_d        = ey_q;
    mx_d        = mx_q;
    my_d        = my_q;
    man_d       = man_q;
    sub_d       = sub_q;
    nan_d       = nan_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sx_d  = a_f.sign;
          ex_d  = a_f.exp;
          mx_d  = fp_mant(a_f);
          sy_d  = b_f.sign;
          ey_d  = b_f.exp;
          my_d  = fp_mant(b_f);
          nan_d = 1'b0;
          ovf_d = 1'b0;
          state_d = ALIGN;
          if (a_nan || b_nan ||
              (a_inf && b_inf && (a_f.sign != b_f.sign))) begin
            sx_d    = 1'b0;
            ex_d    = EXP_MAX;
            man_d   = {2'b00, QNAN[MAN_W-1:0]};
            nan_d   = 1'b1;
            state_d = DONE;
          end else if (a_inf || b_inf) begin
            sx_d    = a_inf ? a_f.sign : b_f.sign;
            ex_d    = EXP_MAX;
            man_d   = '0;
            state_d = DONE;
          end
        end
      end
      ALIGN: begin
        sx_d    = sb;
        ex_d    = eb;
        mx_d    = mb;
        my_d    = ms_sh;
        sub_d   = sb ^ ss;
        state_d = ADD;
      end
      ADD: begin
        man_d = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) :
                        ({1'b0, mx_q} + {1'b0, my_q});
        state_d = NORM;
      end
      NORM: begin
        sx_d  = n_sign;
        ex_d  = n_exp;
        man_d = n_man;
        ovf_d = n_ovf;
        if (n_done) state_d = DONE;
      end
      DONE: begin
        // first DONE cycle packs; the result then holds until taken
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          sum_d       = fp_pack(sx_q, ex_q, man_q[MAN_W-1:0]);
          flags_d     = {nan_q, ovf_q, res_zero};
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      ex_q        <= '0;
      ey_q        <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      man_q       <= '0;
      sub_q       <= 1'b0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      ex_q        <= ex_d;
      ey_q        <= ey_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      man_q       <= man_d;
      sub_q       <= sub_d;
      nan_q       <= nan_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign flags_out = flags_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: arithmetic paths, specials, latency,
// backpressure and mid-operation reset.
module tb_fp_add_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_out;
  logic [2:0]  flags_out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .flags_out (flags_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid after an accept edge; returns cycles waited.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] es,
                       input logic [2:0] ef, input int elat);
    int cyc;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'(elat));
    chk({tag, "_sum"}, sum_out, es);
    chk({tag, "_flg"}, 32'(flags_out), 32'(ef));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ovl"}, 32'(out_valid), 32'd0);
    chk({tag, "_irdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [31:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum_out, 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    do_op("sub3m10", 32'h4040_0000, 32'hC120_0000, 32'hC0E0_0000, 3'b000, 4);
    do_op("one1",    32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, 4);
    do_op("cancel",  32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3'b001, 4);
    do_op("tiny",    32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000, 3'b000, 26);
    do_op("infinf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b100, 1);
    do_op("ovf",     32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b010, 4);
    do_op("inf1",    32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 3'b000, 1);
    do_op("nanin",   32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, 1);
    do_op("denorm",  32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 4);
    do_op("uflow",   32'h8080_0001, 32'h0080_0000, 32'h8000_0000, 3'b001, 4);

    // backpressure: 2.0+2.0 held while a new pair waits on in_valid
    a_in     = 32'h4000_0000;
    b_in     = 32'h4000_0000;
    in_valid = 1'b1;
    tick();
    a_in = 32'h3F80_0000;
    b_in = 32'h3F00_0000;
    wait_out(cyc);
    chk("bp_lat", 32'(cyc), 32'd4);
    chk("bp_sum", sum_out, 32'h4080_0000);
    held = sum_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", sum_out, held);
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_vld", 32'(out_valid), 32'd0);
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_acc_busy", 32'(busy), 32'd1);
    chk("bp_acc_rdy", 32'(in_ready), 32'd0);
    wait_out(cyc);
    chk("bp2_lat", 32'(cyc), 32'd4);
    chk("bp2_sum", sum_out, 32'h3FC0_0000);
    chk("bp2_flg", 32'(flags_out), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset while normalizing the long left-shift case
    a_in     = 32'h3F80_0001;
    b_in     = 32'hBF80_0000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("mid_stale", 32'(out_valid), 32'd0);
    end
    do_op("post_rst", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
